// File: rtl/i8acc_pkg.sv
// Shared types for the int8 accumulator output path: byte/word types, packer states and helpers.
package i8acc_pkg;

  typedef logic signed [7:0] s8_t;
  typedef logic [31:0]       u32_t;

  localparam int unsigned WBYTES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StWrite,
    StFlush
  } pack_st_t;

  function automatic logic [2:0] strb_count(input logic [WBYTES-1:0] strb);
    logic [2:0] cnt;
    cnt = '0;
    for (int k = 0; k < WBYTES; k++) begin
      cnt = cnt + {2'b00, strb[k]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/i8pack_fifo.sv
// Synchronous lane-vector FIFO; a push into a full FIFO is accepted when a pop happens
// in the same cycle.
module i8pack_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             xreset,
  input  logic             clear,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wr_q, rd_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i8out_pack.sv
// Packs s8 lane vectors into little-endian 32-bit output words with byte strobes.
// Optional byte counter output wcount when I8PACK_BYTECNT_EN is defined.
module i8out_pack
  import i8acc_pkg::*;
#(
  parameter int unsigned NLANE  = 4,
  parameter int unsigned FDEPTH = 4
) (
  input  logic               clk,
  input  logic               xreset,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic               flush,
  input  logic               acvalid,
  input  logic [NLANE*8-1:0] accd,
  output logic               wvalid,
  input  logic               wready,
  output logic [31:0]        waddr,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
`ifdef I8PACK_BYTECNT_EN
  output logic [31:0]        wcount,
`endif
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int unsigned LiW = (NLANE > 1) ? $clog2(NLANE) : 1;

  typedef s8_t [NLANE-1:0] lanev_t;

  pack_st_t                  state_q, state_d;
  u32_t                      wptr_q, wptr_d;
  logic [1:0]                bp_q, bp_d;
  logic [LiW-1:0]            li_q, li_d;
  logic [WBYTES-1:0][7:0]    data_q, data_d;
  logic [WBYTES-1:0]         strb_q, strb_d;
  logic                      flush_pend_q, flush_pend_d;
  logic                      ovf_q, ovf_d;

  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NLANE*8-1:0]        fifo_rdata;
  lanev_t                    head;
  logic                      lane_last;

  assign head      = fifo_rdata;
  assign lane_last = (li_q == LiW'(NLANE - 1));
  assign fifo_push = acvalid && (state_q != StIdle) && !start;

  i8pack_fifo #(
    .Width (NLANE * 8),
    .Depth (FDEPTH)
  ) u_fifo (
    .clk    (clk),
    .xreset (xreset),
    .clear  (start),
    .push   (fifo_push),
    .wdata  (accd),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    bp_d         = bp_q;
    li_d         = li_q;
    data_d       = data_q;
    strb_d       = strb_q;
    flush_pend_d = flush_pend_q;
    ovf_d        = ovf_q;
    fifo_pop     = 1'b0;

    if (start) begin
      state_d      = StPack;
      wptr_d       = {base_addr[31:2], 2'b00};
      bp_d         = base_addr[1:0];
      li_d         = '0;
      data_d       = '0;
      strb_d       = '0;
      flush_pend_d = 1'b0;
      ovf_d        = 1'b0;
    end else begin
      if (flush && (state_q != StIdle)) flush_pend_d = 1'b1;

      unique case (state_q)
        StIdle: ;
        StPack: begin
          if (!fifo_empty) begin
            data_d[bp_q] = head[li_q];
            strb_d[bp_q] = 1'b1;
            bp_d         = bp_q + 2'd1;
            if (lane_last) begin
              fifo_pop = 1'b1;
              li_d     = '0;
            end else begin
              li_d = li_q + 1'b1;
            end
            if ((bp_q == 2'd3) || ((strb_q | (4'b0001 << bp_q)) == 4'hF)) state_d = StWrite;
          end else if (flush_pend_q && (li_q == '0)) begin
            state_d = (strb_q != '0) ? StWrite : StFlush;
          end
        end
        StWrite: begin
          if (wready) begin
            wptr_d = wptr_q + 32'd4;
            strb_d = '0;
            data_d = '0;
            // Last (possibly partial) word accepted with nothing left to pack.
            if (flush_pend_q && fifo_empty && !fifo_push && (li_q == '0)) state_d = StFlush;
            else                                                           state_d = StPack;
          end
        end
        StFlush: begin
          state_d      = StIdle;
          flush_pend_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase

      if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      bp_q         <= '0;
      li_q         <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      flush_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      bp_q         <= bp_d;
      li_q         <= li_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      flush_pend_q <= flush_pend_d;
      ovf_q        <= ovf_d;
    end
  end

  assign wvalid   = (state_q == StWrite);
  assign waddr    = wptr_q;
  assign wdata    = data_q;
  assign wstrb    = strb_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFlush);
  assign overflow = ovf_q;

`ifdef I8PACK_BYTECNT_EN
  u32_t cnt_q;

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (wvalid && wready) begin
      cnt_q <= cnt_q + u32_t'(strb_count(strb_q));
    end
  end

  assign wcount = cnt_q;
`endif

endmodule

// File: tb/tb_i8out_pack.sv
// Directed self-checking bench for i8out_pack (NLANE=4, FDEPTH=4).
module tb_i8out_pack;

  localparam int NLANE  = 4;
  localparam int FDEPTH = 4;

  logic              clk = 1'b0;
  logic              xreset;
  logic              start, flush, acvalid, wready;
  logic [31:0]       base_addr;
  logic [NLANE*8-1:0] accd;
  logic              wvalid, busy, done, overflow;
  logic [31:0]       waddr, wdata;
  logic [3:0]        wstrb;
`ifdef I8PACK_BYTECNT_EN
  logic [31:0]       wcount;
`endif

  int errs   = 0;
  int checks = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];

  always #5 clk = ~clk;

  i8out_pack #(
    .NLANE  (NLANE),
    .FDEPTH (FDEPTH)
  ) dut (
    .clk       (clk),
    .xreset    (xreset),
    .start     (start),
    .base_addr (base_addr),
    .flush     (flush),
    .acvalid   (acvalid),
    .accd      (accd),
    .wvalid    (wvalid),
    .wready    (wready),
    .waddr     (waddr),
    .wdata     (wdata),
    .wstrb     (wstrb),
`ifdef I8PACK_BYTECNT_EN
    .wcount    (wcount),
`endif
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  // Record every accepted write.
  always @(posedge clk) begin
    if (xreset && wvalid && wready && !start) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      ws_q.push_back(wstrb);
    end
  end

  function automatic logic [31:0] smask(input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction

  task automatic do_start(input logic [31:0] b);
    base_addr = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wa_q.delete();
    wd_q.delete();
    ws_q.delete();
  endtask

  task automatic do_push(input logic [31:0] v);
    accd    = v;
    acvalid = 1'b1;
    @(negedge clk);
    acvalid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_wvalid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (wvalid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    xreset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wvalid, busy, done, overflow} !== 4'b0000)
      begin errs++; $display("FAIL reset_flags: got %b want 0000", {wvalid, busy, done, overflow}); end
    checks++;
    if (waddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0)
      begin errs++; $display("FAIL reset_bus: got %h/%h/%h want zeros", waddr, wdata, wstrb); end
    xreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned();
    bit seen;
    wready = 1'b1;
    do_start(32'h0000_1000);
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL aligned_busy: got %b want 1", busy); end
    do_push(32'h0403_0201);
    do_flush();
    wait_done(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL aligned_done: done not seen within budget"); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      begin errs++; $display("FAIL aligned_idle: busy=%b done=%b want 0 0", busy, done); end
    checks++;
    if (wa_q.size() != 1) begin errs++; $display("FAIL aligned_count: got %0d want 1", wa_q.size()); end
    else if (wa_q[0] !== 32'h1000 || wd_q[0] !== 32'h0403_0201 || ws_q[0] !== 4'hF) begin
      errs++;
      $display("FAIL aligned_word: got %h %h %h want 00001000 04030201 f", wa_q[0], wd_q[0], ws_q[0]);
    end
  endtask

  task automatic test_unaligned();
    bit seen;
    logic [31:0] ea[3] = '{32'h2000, 32'h2004, 32'h2008};
    logic [31:0] ed[3] = '{32'h0201_0000, 32'h0605_0403, 32'h0000_0807};
    logic [3:0]  es[3] = '{4'hC, 4'hF, 4'h3};
    wready = 1'b1;
    do_start(32'h0000_2002);
    do_push(32'h0403_0201);
    do_push(32'h0807_0605);
    do_flush();
    wait_done(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL unaligned_done: done not seen within budget"); end
    checks++;
    if (wa_q.size() != 3) begin errs++; $display("FAIL unaligned_count: got %0d want 3", wa_q.size()); end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea[i] || ws_q[i] !== es[i] || (wd_q[i] & smask(es[i])) !== ed[i]) begin
        errs++;
        $display("FAIL unaligned_w%0d: got %h %h %h want %h %h %h", i, wa_q[i], wd_q[i], ws_q[i],
                 ea[i], ed[i], es[i]);
      end
    end
`ifdef I8PACK_BYTECNT_EN
    checks++;
    if (wcount !== 32'd8) begin errs++; $display("FAIL unaligned_wcount: got %0d want 8", wcount); end
`endif
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [31:0] vec[4] = '{32'h4433_2211, 32'h8877_6655, 32'hCCBB_AA99, 32'h00FF_EEDD};
    wready = 1'b0;
    do_start(32'h0000_3000);
    do_push(vec[0]);
    wait_wvalid(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL bp_wvalid: wvalid not seen within budget"); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wvalid !== 1'b1 || waddr !== 32'h3000 || wdata !== vec[0] || wstrb !== 4'hF) begin
        errs++;
        $display("FAIL bp_hold%0d: got %b %h %h %h want 1 00003000 %h f", i, wvalid, waddr,
                 wdata, wstrb, vec[0]);
      end
      if (i < 3) begin accd = vec[i+1]; acvalid = 1'b1; end
      else acvalid = 1'b0;
      @(negedge clk);
    end
    acvalid = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errs++; $display("FAIL bp_ovf: got %b want 0", overflow); end
    wready = 1'b1;
    do_flush();
    wait_done(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL bp_done: done not seen within budget"); end
    checks++;
    if (wa_q.size() != 4) begin errs++; $display("FAIL bp_count: got %0d want 4", wa_q.size()); end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'h3000 + 32'(4*i) || wd_q[i] !== vec[i] || ws_q[i] !== 4'hF) begin
        errs++;
        $display("FAIL bp_w%0d: got %h %h %h want %h %h f", i, wa_q[i], wd_q[i], ws_q[i],
                 32'h3000 + 32'(4*i), vec[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit seen;
    logic [31:0] ea[5] = '{32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h4010};
    logic [31:0] ed[5] = '{32'h1100_0000, 32'h2114_1312, 32'h3124_2322, 32'h4134_3332,
                           32'h0044_4342};
    logic [3:0]  es[5] = '{4'h8, 4'hF, 4'hF, 4'hF, 4'h7};
    wready = 1'b0;
    // Offset 3 stalls the packer in WRITE after one byte, before the first vector is popped.
    do_start(32'h0000_4003);
    do_push(32'h1413_1211);
    do_push(32'h2423_2221);
    do_push(32'h3433_3231);
    do_push(32'h4443_4241);
    checks++;
    if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_before: got %b want 0", overflow); end
    do_push(32'h5453_5251);
    checks++;
    if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b want 1", overflow); end
    wready = 1'b1;
    do_flush();
    wait_done(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL ovf_done: done not seen within budget"); end
    checks++;
    if (wa_q.size() != 5) begin errs++; $display("FAIL ovf_count: got %0d want 5", wa_q.size()); end
    for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea[i] || ws_q[i] !== es[i] || (wd_q[i] & smask(es[i])) !== ed[i]) begin
        errs++;
        $display("FAIL ovf_w%0d: got %h %h %h want %h %h %h", i, wa_q[i], wd_q[i], ws_q[i],
                 ea[i], ed[i], es[i]);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    do_start(32'h0000_4000);
    checks++;
    if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_restart_mid_write();
    bit seen;
    wready = 1'b0;
    do_start(32'h0000_5000);
    do_push(32'hA3A2_A1A0);
    wait_wvalid(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL restart_wvalid: wvalid not seen within budget"); end
    do_push(32'hB3B2_B1B0);
    do_start(32'h0000_6000);
    checks++;
    if (wvalid !== 1'b0 || busy !== 1'b1)
      begin errs++; $display("FAIL restart_drop: wvalid=%b busy=%b want 0 1", wvalid, busy); end
    wready = 1'b1;
    do_push(32'hC3C2_C1C0);
    do_flush();
    wait_done(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL restart_done: done not seen within budget"); end
    checks++;
    if (wa_q.size() != 1) begin errs++; $display("FAIL restart_count: got %0d want 1", wa_q.size()); end
    else if (wa_q[0] !== 32'h6000 || wd_q[0] !== 32'hC3C2_C1C0 || ws_q[0] !== 4'hF) begin
      errs++;
      $display("FAIL restart_word: got %h %h %h want 00006000 c3c2c1c0 f", wa_q[0], wd_q[0], ws_q[0]);
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    wready = 1'b0;
    do_start(32'h0000_7000);
    do_push(32'hD3D2_D1D0);
    wait_wvalid(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL rstmid_wvalid: wvalid not seen within budget"); end
    #2 xreset = 1'b0;
    #1;
    checks++;
    if (wvalid !== 1'b0 || busy !== 1'b0 || waddr !== 32'h0)
      begin errs++; $display("FAIL rstmid_drop: wvalid=%b busy=%b waddr=%h want 0 0 0", wvalid, busy, waddr); end
    @(negedge clk);
    xreset = 1'b1;
    @(negedge clk);
    wready = 1'b1;
    do_start(32'h0000_8000);
    do_push(32'hE3E2_E1E0);
    do_flush();
    wait_done(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL rstmid_done: done not seen within budget"); end
    checks++;
    if (wa_q.size() != 1) begin errs++; $display("FAIL rstmid_count: got %0d want 1", wa_q.size()); end
    else if (wa_q[0] !== 32'h8000 || wd_q[0] !== 32'hE3E2_E1E0) begin
      errs++;
      $display("FAIL rstmid_word: got %h %h want 00008000 e3e2e1e0", wa_q[0], wd_q[0]);
    end
  endtask

  task automatic test_flush_empty();
    bit seen;
    wready = 1'b1;
    do_start(32'h0000_9000);
    do_flush();
    wait_done(seen);
    checks++;
    if (!seen) begin errs++; $display("FAIL empty_done: done not seen within budget"); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL empty_busy: got %b want 0", busy); end
    checks++;
    if (wa_q.size() != 0) begin errs++; $display("FAIL empty_count: got %0d want 0", wa_q.size()); end
`ifdef I8PACK_BYTECNT_EN
    checks++;
    if (wcount !== 32'd0) begin errs++; $display("FAIL empty_wcount: got %0d want 0", wcount); end
`endif
    // Flush and vectors while idle are ignored.
    do_flush();
    do_push(32'h1234_5678);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wvalid !== 1'b0 || done !== 1'b0)
      begin errs++; $display("FAIL idle_ignore: busy=%b wvalid=%b done=%b want 0 0 0", busy, wvalid, done); end
  endtask

  initial begin
    xreset    = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    acvalid   = 1'b0;
    accd      = '0;
    base_addr = '0;
    wready    = 1'b0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_backpressure();
    test_overflow();
    test_restart_mid_write();
    test_reset_mid_write();
    test_flush_empty();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
